// File: rtl/score_arbiter.sv
// Purpose : owns both players' scores (binary + BCD) and arbitrates one update per clock.
// Latency : a request pulse is captured on edge N and applied on edge N+1 (2 cycles to outputs).
// Backpres: one-deep pending slot per request; a repeat pulse into a busy slot is lost and flagged.
// Ports   : clk_1khz/rst_i (sync, active-high); p1/p2 inc/dec and clear_i request pulses;
//           p1/p2 tens/ones BCD digits; game_over_o, winner_o (01 P1, 10 P2); dropped_o pulse.
module score_arbiter #(
    parameter int WIN_SCORE  = 11,
    parameter int WIN_MARGIN = 2,
    parameter int MAX_SCORE  = 99
) (
    input  logic       clk_1khz,
    input  logic       rst_i,
    input  logic       p1_inc_i,
    input  logic       p1_dec_i,
    input  logic       p2_inc_i,
    input  logic       p2_dec_i,
    input  logic       clear_i,
    output logic [3:0] p1_tens_o,
    output logic [3:0] p1_ones_o,
    output logic [3:0] p2_tens_o,
    output logic [3:0] p2_ones_o,
    output logic       game_over_o,
    output logic [1:0] winner_o,
    output logic       dropped_o
);

    localparam logic [0:0] PLAYING   = 1'b0;
    localparam logic [0:0] GAME_OVER = 1'b1;

    localparam logic [7:0] WIN_L    = 8'(WIN_SCORE);
    localparam logic [7:0] MARGIN_L = 8'(WIN_MARGIN);
    localparam logic [7:0] MAX_L    = 8'(MAX_SCORE);

    logic [0:0] state;
    logic [6:0] s1, s2;
    logic [3:0] t1, o1, t2, o2;
    logic [1:0] winner;
    logic       dropped;
    logic       pend_clr, pend_p1i, pend_p1d, pend_p2i, pend_p2d;
    logic       last_p2;    // 1: player 2 won the most recent contested grant

    logic       w1, w2, g_clr, g1, g2;
    logic       sel_inc, sel_dec, op_inc, op_dec;
    logic [6:0] cur_s, new_s;
    logic [3:0] cur_t, cur_o, new_t, new_o;
    logic [7:0] n1, n2;
    logic       cond1, cond2;
    logic [0:0] state_nx;
    logic [1:0] winner_nx;

    always_comb begin
        w1    = pend_p1i | pend_p1d;
        w2    = pend_p2i | pend_p2d;
        g_clr = pend_clr;
        // Contested: the player that did not win last time goes next.
        g1    = !pend_clr && w1 && (!w2 || last_p2);
        g2    = !pend_clr && w2 && (!w1 || !last_p2);

        sel_inc = g1 ? pend_p1i : (g2 & pend_p2i);
        sel_dec = g1 ? pend_p1d : (g2 & pend_p2d);
        // inc and dec pending together cancel out.
        op_inc  = sel_inc & ~sel_dec;
        op_dec  = sel_dec & ~sel_inc;

        cur_s = g1 ? s1 : s2;
        cur_t = g1 ? t1 : t2;
        cur_o = g1 ? o1 : o2;
        new_s = cur_s;
        new_t = cur_t;
        new_o = cur_o;
        // Increments are no-ops once the game is decided; decrements always apply.
        if (op_inc && (state == PLAYING) && ({1'b0, cur_s} < MAX_L)) begin
            new_s = cur_s + 7'd1;
            if (cur_o == 4'd9) begin
                new_o = 4'd0;
                new_t = cur_t + 4'd1;
            end else begin
                new_o = cur_o + 4'd1;
            end
        end else if (op_dec && (cur_s != 7'd0)) begin
            new_s = cur_s - 7'd1;
            if (cur_o == 4'd0) begin
                new_o = 4'd9;
                new_t = cur_t - 4'd1;
            end else begin
                new_o = cur_o - 4'd1;
            end
        end

        // Win test on the post-update scores.
        n1    = {1'b0, (g1 ? new_s : s1)};
        n2    = {1'b0, (g2 ? new_s : s2)};
        cond1 = (n1 >= WIN_L) && (n1 >= n2 + MARGIN_L);
        cond2 = (n2 >= WIN_L) && (n2 >= n1 + MARGIN_L);

        state_nx  = state;
        winner_nx = winner;
        if (state == PLAYING) begin
            if (g1 && (op_inc || op_dec) && cond1) begin
                state_nx  = GAME_OVER;
                winner_nx = 2'b01;
            end else if (g2 && (op_inc || op_dec) && cond2) begin
                state_nx  = GAME_OVER;
                winner_nx = 2'b10;
            end
        end else if (op_dec && !((winner == 2'b01) ? cond1 : cond2)) begin
            // A correction took away the winner's margin: resume play.
            state_nx  = PLAYING;
            winner_nx = 2'b00;
        end
    end

    always_ff @(posedge clk_1khz) begin
        if (rst_i) begin
            state    <= PLAYING;
            s1       <= 7'd0;
            s2       <= 7'd0;
            t1       <= 4'd0;
            o1       <= 4'd0;
            t2       <= 4'd0;
            o2       <= 4'd0;
            winner   <= 2'b00;
            dropped  <= 1'b0;
            pend_clr <= 1'b0;
            pend_p1i <= 1'b0;
            pend_p1d <= 1'b0;
            pend_p2i <= 1'b0;
            pend_p2d <= 1'b0;
            last_p2  <= 1'b1;
        end else begin
            // A pulse whose slot is still occupied after this edge's grant is lost.
            dropped  <= (p1_inc_i & pend_p1i & ~(g_clr | g1)) |
                        (p1_dec_i & pend_p1d & ~(g_clr | g1)) |
                        (p2_inc_i & pend_p2i & ~(g_clr | g2)) |
                        (p2_dec_i & pend_p2d & ~(g_clr | g2));
            // A pending clear is always granted, so its slot only ever holds the new pulse.
            pend_clr <= clear_i;
            pend_p1i <= p1_inc_i | (pend_p1i & ~(g_clr | g1));
            pend_p1d <= p1_dec_i | (pend_p1d & ~(g_clr | g1));
            pend_p2i <= p2_inc_i | (pend_p2i & ~(g_clr | g2));
            pend_p2d <= p2_dec_i | (pend_p2d & ~(g_clr | g2));

            if (w1 && w2 && !g_clr) begin
                last_p2 <= g2;
            end

            if (g_clr) begin
                s1     <= 7'd0;
                s2     <= 7'd0;
                t1     <= 4'd0;
                o1     <= 4'd0;
                t2     <= 4'd0;
                o2     <= 4'd0;
                state  <= PLAYING;
                winner <= 2'b00;
            end else begin
                if (g1) begin
                    s1 <= new_s;
                    t1 <= new_t;
                    o1 <= new_o;
                end
                if (g2) begin
                    s2 <= new_s;
                    t2 <= new_t;
                    o2 <= new_o;
                end
                state  <= state_nx;
                winner <= winner_nx;
            end
        end
    end

    assign p1_tens_o   = t1;
    assign p1_ones_o   = o1;
    assign p2_tens_o   = t2;
    assign p2_ones_o   = o2;
    assign game_over_o = (state == GAME_OVER);
    assign winner_o    = winner;
    assign dropped_o   = dropped;

endmodule

// File: tb/tb_score_arbiter.sv
// Purpose : self-checking bench for score_arbiter (directed table, corner sequences, random vs model).
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled 1 unit after the next.
// Backpres: none; every phase runs a fixed number of cycles.
module tb_score_arbiter;

    logic       clk_1khz = 1'b0;
    logic       rst_i = 1'b1;
    logic       p1_inc_i = 1'b0, p1_dec_i = 1'b0, p2_inc_i = 1'b0, p2_dec_i = 1'b0, clear_i = 1'b0;
    logic [3:0] p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o;
    logic       game_over_o;
    logic [1:0] winner_o;
    logic       dropped_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_1khz = ~clk_1khz;

    score_arbiter #(.WIN_SCORE(11), .WIN_MARGIN(2), .MAX_SCORE(99)) dut (
        .clk_1khz(clk_1khz), .rst_i(rst_i),
        .p1_inc_i(p1_inc_i), .p1_dec_i(p1_dec_i),
        .p2_inc_i(p2_inc_i), .p2_dec_i(p2_dec_i),
        .clear_i(clear_i),
        .p1_tens_o(p1_tens_o), .p1_ones_o(p1_ones_o),
        .p2_tens_o(p2_tens_o), .p2_ones_o(p2_ones_o),
        .game_over_o(game_over_o), .winner_o(winner_o), .dropped_o(dropped_o)
    );

    // Input vector bit order: {clear, p2_dec, p2_inc, p1_dec, p1_inc}
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] P1I  = 5'b00001;
    localparam logic [4:0] P1D  = 5'b00010;
    localparam logic [4:0] P2I  = 5'b00100;
    localparam logic [4:0] P2D  = 5'b01000;
    localparam logic [4:0] CLR  = 5'b10000;

    // ---------------- reference model (game-level rules on integers) ----------------
    int m_score[2] = '{0, 0};
    bit m_inc[2]   = '{0, 0};
    bit m_dec[2]   = '{0, 0};
    bit m_clr      = 0;
    int m_last     = 1;     // index of player granted in the last tie
    bit m_over     = 0;
    int m_winner   = 0;     // 0 none, 1 player 1, 2 player 2
    bit m_drop     = 0;

    function automatic bit wins(int p);
        return (m_score[p] >= 11) && (m_score[p] - m_score[1 - p] >= 2);
    endfunction

    task automatic model_step(input logic [4:0] in, input bit rst);
        bit ninc[2];
        bit ndec[2];
        bit gclr;
        bit i;
        bit d;
        int gp;
        ninc[0] = in[0]; ndec[0] = in[1];
        ninc[1] = in[2]; ndec[1] = in[3];
        if (rst) begin
            m_score = '{0, 0}; m_inc = '{0, 0}; m_dec = '{0, 0};
            m_clr = 0; m_last = 1; m_over = 0; m_winner = 0; m_drop = 0;
            return;
        end
        gclr = m_clr;
        gp   = -1;
        if (!gclr) begin
            if ((m_inc[0] || m_dec[0]) && (m_inc[1] || m_dec[1])) begin
                gp     = 1 - m_last;
                m_last = gp;
            end else if (m_inc[0] || m_dec[0]) begin
                gp = 0;
            end else if (m_inc[1] || m_dec[1]) begin
                gp = 1;
            end
        end
        m_drop = 0;
        for (int p = 0; p < 2; p++) begin
            if (!(gclr || gp == p) && ((ninc[p] && m_inc[p]) || (ndec[p] && m_dec[p])))
                m_drop = 1;
        end
        if (gclr) begin
            m_score = '{0, 0}; m_inc = '{0, 0}; m_dec = '{0, 0};
            m_over = 0; m_winner = 0;
        end else if (gp >= 0) begin
            i = m_inc[gp];
            d = m_dec[gp];
            if (i != d) begin
                if (d) begin
                    if (m_score[gp] > 0) m_score[gp] = m_score[gp] - 1;
                end else if (!m_over && m_score[gp] < 99) begin
                    m_score[gp] = m_score[gp] + 1;
                end
                if (!m_over) begin
                    if (wins(gp)) begin
                        m_over   = 1;
                        m_winner = gp + 1;
                    end
                end else if (d && !wins(m_winner - 1)) begin
                    m_over   = 0;
                    m_winner = 0;
                end
            end
            m_inc[gp] = 0;
            m_dec[gp] = 0;
        end
        m_clr = in[4];
        for (int p = 0; p < 2; p++) begin
            if (ninc[p]) m_inc[p] = 1;
            if (ndec[p]) m_dec[p] = 1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_score(input string name, input int e1, input int e2);
        cmp({name, " p1_tens"}, int'(p1_tens_o), e1 / 10);
        cmp({name, " p1_ones"}, int'(p1_ones_o), e1 % 10);
        cmp({name, " p2_tens"}, int'(p2_tens_o), e2 / 10);
        cmp({name, " p2_ones"}, int'(p2_ones_o), e2 % 10);
    endtask

    task automatic cmp_state(input string name, input int go, input int win);
        cmp({name, " game_over"}, int'(game_over_o), go);
        cmp({name, " winner"}, int'(winner_o), win);
    endtask

    task automatic step(input logic [4:0] in, input bit rst);
        {clear_i, p2_dec_i, p2_inc_i, p1_dec_i, p1_inc_i} = in;
        rst_i = rst;
        @(posedge clk_1khz);
        model_step(in, rst);
        #1;
        {clear_i, p2_dec_i, p2_inc_i, p1_dec_i, p1_inc_i} = NONE;
        rst_i = 1'b0;
    endtask

    task automatic pulse(input logic [4:0] in);
        step(in, 0);
        step(NONE, 0);
        step(NONE, 0);
    endtask

    task automatic do_reset();
        step(NONE, 1);
        step(NONE, 1);
    endtask

    typedef struct {
        logic [4:0] in;
        int         e1;
        int         e2;
        bit         drop;
    } vec_t;

    vec_t tbl[23];

    initial begin
        // Rows: inputs for one cycle, expected outputs just after the edge that samples them.
        tbl[0]  = '{P1I,       0, 0, 0};
        tbl[1]  = '{NONE,      1, 0, 0};   // uncontested, 2 cycles
        tbl[2]  = '{P1I | P2I, 1, 0, 0};
        tbl[3]  = '{NONE,      2, 0, 0};   // tie: P1 first after reset
        tbl[4]  = '{NONE,      2, 1, 0};
        tbl[5]  = '{P1I | P2I, 2, 1, 0};
        tbl[6]  = '{NONE,      2, 2, 0};   // tie: P2 first this time
        tbl[7]  = '{NONE,      3, 2, 0};
        tbl[8]  = '{P1I | P2I, 3, 2, 0};
        tbl[9]  = '{NONE,      4, 2, 0};
        tbl[10] = '{NONE,      4, 3, 0};
        tbl[11] = '{P1I | P2I, 4, 3, 0};
        tbl[12] = '{P1I,       4, 4, 1};   // P2 granted, P1 repeat lost
        tbl[13] = '{NONE,      5, 4, 0};
        tbl[14] = '{NONE,      5, 4, 0};   // only one P1 point
        tbl[15] = '{CLR,       5, 4, 0};
        tbl[16] = '{NONE,      0, 0, 0};
        tbl[17] = '{P1D,       0, 0, 0};
        tbl[18] = '{NONE,      0, 0, 0};   // dec at 0 holds
        tbl[19] = '{P2I | P2D, 0, 0, 0};
        tbl[20] = '{NONE,      0, 0, 0};   // inc+dec cancel
        tbl[21] = '{P2I,       0, 0, 0};
        tbl[22] = '{NONE,      0, 1, 0};

        // Reset state
        do_reset();
        cmp_score("reset", 0, 0);
        cmp_state("reset", 0, 0);
        cmp("reset dropped", int'(dropped_o), 0);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].in, 0);
            cmp_score($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2);
            cmp($sformatf("vec%0d dropped", i), int'(dropped_o), int'(tbl[i].drop));
        end

        // BCD carry/borrow across the ones digit
        do_reset();
        for (int i = 0; i < 9; i++) pulse(P1I);
        cmp_score("nine", 9, 0);
        pulse(P1I);
        cmp_score("carry", 10, 0);
        pulse(P1D);
        cmp_score("borrow", 9, 0);

        // Deuce, win, correction, clear
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pulse(P1I);
            pulse(P2I);
        end
        cmp_score("deuce", 10, 10);
        pulse(P1I);
        cmp_score("adv", 11, 10);
        cmp_state("adv", 0, 0);
        step(P1I, 0);
        cmp_state("pre win", 0, 0);
        step(NONE, 0);
        cmp_score("win", 12, 10);
        cmp_state("win", 1, 1);
        step(NONE, 0);
        pulse(P1I);
        cmp_score("inc ignored", 12, 10);
        cmp_state("inc ignored", 1, 1);
        pulse(P1D);
        cmp_score("correction", 11, 10);
        cmp_state("correction", 0, 0);
        pulse(P1I);
        cmp_state("rewin", 1, 1);
        pulse(CLR);
        cmp_score("clear", 0, 0);
        cmp_state("clear", 0, 0);

        // Reset while both players contend
        pulse(P1I);
        pulse(P2I);
        step(P1I | P2I, 0);
        step(NONE, 1);
        cmp_score("mid rst", 0, 0);
        cmp_state("mid rst", 0, 0);
        step(NONE, 0);
        step(NONE, 0);
        cmp_score("after rst", 0, 0);
        cmp("after rst dropped", int'(dropped_o), 0);

        // Saturation at 99 without a winning margin
        do_reset();
        for (int i = 0; i < 98; i++) begin
            pulse(P1I);
            pulse(P2I);
        end
        pulse(P1I);
        pulse(P2I);
        cmp_score("tie 99", 99, 99);
        pulse(P1I);
        cmp_score("saturate", 99, 99);
        cmp_state("saturate", 0, 0);

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic [4:0] in;
            bit         r;
            in[0] = ($urandom_range(0, 99) < 20);
            in[1] = ($urandom_range(0, 99) < 6);
            in[2] = ($urandom_range(0, 99) < 20);
            in[3] = ($urandom_range(0, 99) < 6);
            in[4] = ($urandom_range(0, 999) < 3);
            r     = ($urandom_range(0, 999) < 2);
            step(in, r);
            cmp_score($sformatf("rnd%0d", c), m_score[0], m_score[1]);
            cmp_state($sformatf("rnd%0d", c), int'(m_over), m_winner);
            cmp($sformatf("rnd%0d dropped", c), int'(dropped_o), int'(m_drop));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
